uart_rx_frame_checker: RTL

//  Per-frame integrity checker for the UART receiver, replacing single-mode parity checking.

---
 rtl/uart_rx_frame_checker.sv | 105 ++++++++++
 1 files changed

// File: rtl/uart_rx_frame_checker.sv
// uart_rx_frame_checker: per-frame parity/stop-bit verdict with saturating error counters
module uart_rx_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    input  logic                  par_chk_en,
    input  logic                  stp_chk_en,
    input  logic                  sampled_bit,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] RX_DATA_OUT,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);
    typedef enum logic [1:0] {IDLE, PARITY, STOP, REPORT} state_t;

    state_t                state, next;
    logic                  par_en_q;
    logic [1:0]            par_mode_q;
    logic                  par_flag, stp_flag;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  exp_par, par_hit, stp_hit, good;

    assign exp_par = par_mode_q[1] ? ~par_mode_q[0] : (^P_DATA) ^ par_mode_q[0];
    assign par_hit = (state == PARITY) & par_chk_en & ~frame_start;
    assign stp_hit = (state == STOP) & stp_chk_en & ~frame_start;
    assign good    = ~par_flag & sampled_bit;

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next;
    end

    // next state: frame_start restarts from any state, otherwise one step per legal strobe
    always_comb begin
        next = state;
        if (frame_start)
            next = PAR_EN ? PARITY : STOP;
        else if (state == PARITY)
            next = par_chk_en ? STOP : PARITY;
        else if (state == STOP)
            next = stp_chk_en ? REPORT : STOP;
        else if (state == REPORT)
            next = IDLE;
    end

    // frame config, per-frame flags, registered verdict pulses and last good word
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_q    <= 1'b0;
            par_mode_q  <= 2'b00;
            par_flag    <= 1'b0;
            stp_flag    <= 1'b0;
            data_q      <= '0;
            RX_DATA_OUT <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (frame_start) begin
                par_en_q   <= PAR_EN;
                par_mode_q <= PAR_MODE;
                par_flag   <= 1'b0;
                stp_flag   <= 1'b0;
            end
            if (par_hit) begin
                par_flag <= sampled_bit != exp_par;
                data_q   <= P_DATA;
            end
            if (stp_hit) begin
                stp_flag   <= ~sampled_bit;
                data_valid <= good;
                par_err    <= par_flag;
                stp_err    <= ~sampled_bit;
                if (good) RX_DATA_OUT <= par_en_q ? data_q : P_DATA;
            end
        end
    end

    // saturating error counters bumped while the verdict is on the outputs; clear wins
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (err_clr) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (state == REPORT) begin
            if (par_flag && !(&par_err_cnt)) par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
            if (stp_flag && !(&stp_err_cnt)) stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
        end
    end
endmodule
